// File: rtl/hdmi_timing_pattern_gen.sv
// Video timing generator with four test patterns; all outputs aligned at 2 clk after the raster counters.
// No backpressure: the sink consumes one pixel every clock, and pattern changes only take effect at frame start.
module hdmi_timing_pattern_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        hdmi_hs,
    output logic        hdmi_vs,
    output logic        hdmi_de,
    output logic [7:0]  hdmi_r,
    output logic [7:0]  hdmi_g,
    output logic [7:0]  hdmi_b,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    // Stage 0: raster counters and region decode
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          act0, hs0, vs0, sof0, y5_d;
    logic [7:0]    x8_d;
    logic [BW-1:0] bar_pix_q, bar_pix_d;
    logic [3:0]    bar_idx_q, bar_idx_d;

    // Stage 1 registers and frame-latched pattern controls
    logic          act1_q, hs1_q, vs1_q, sof1_q, y5_q;
    logic [7:0]    x8_q;
    logic [1:0]    pat_q;
    logic [23:0]   solid_q;
    logic [23:0]   rgb_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_MAX) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 1'b1;
        end

        act0 = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs0  = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
        vs0  = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
        sof0 = (h_cnt_q == '0) && (v_cnt_q == '0);
        x8_d = 8'(h_cnt_q);
        y5_d = |(v_cnt_q & VW'(32));

        // Bar position tracked incrementally; index 8 means past the last bar
        bar_pix_d = bar_pix_q + 1'b1;
        bar_idx_d = bar_idx_q;
        if (h_cnt_q == '0) begin
            bar_pix_d = '0;
            bar_idx_d = '0;
        end else if (bar_pix_q == BAR_LAST) begin
            bar_pix_d = '0;
            if (bar_idx_q != 4'd8)
                bar_idx_d = bar_idx_q + 1'b1;
        end
    end

    // Stage 2 colour selection from stage-1 state
    always_comb begin
        rgb_d = 24'h000000;
        case (pat_q)
            2'd0: begin
                case (bar_idx_q)
                    4'd0:    rgb_d = 24'hFFFFFF;
                    4'd1:    rgb_d = 24'hFFFF00;
                    4'd2:    rgb_d = 24'h00FFFF;
                    4'd3:    rgb_d = 24'h00FF00;
                    4'd4:    rgb_d = 24'hFF00FF;
                    4'd5:    rgb_d = 24'hFF0000;
                    4'd6:    rgb_d = 24'h0000FF;
                    default: rgb_d = 24'h000000;
                endcase
            end
            2'd1:    rgb_d = {x8_q, x8_q, x8_q};
            2'd2:    rgb_d = (x8_q[5] ^ y5_q) ? 24'h000000 : 24'hFFFFFF;
            default: rgb_d = solid_q;
        endcase
        if (!act1_q)
            rgb_d = 24'h000000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            bar_pix_q   <= '0;
            bar_idx_q   <= '0;
            act1_q      <= 1'b0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            sof1_q      <= 1'b0;
            x8_q        <= '0;
            y5_q        <= 1'b0;
            pat_q       <= '0;
            solid_q     <= '0;
            hdmi_hs     <= ~HS_POL;
            hdmi_vs     <= ~VS_POL;
            hdmi_de     <= 1'b0;
            hdmi_r      <= '0;
            hdmi_g      <= '0;
            hdmi_b      <= '0;
            frame_start <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            act1_q    <= act0;
            hs1_q     <= hs0;
            vs1_q     <= vs0;
            sof1_q    <= sof0;
            x8_q      <= x8_d;
            y5_q      <= y5_d;
            // Latched as pixel (0,0) enters stage 1, so the whole frame sees one pattern
            if (sof0) begin
                pat_q   <= pattern_sel;
                solid_q <= solid_rgb;
            end
            hdmi_hs     <= hs1_q ? HS_POL : ~HS_POL;
            hdmi_vs     <= vs1_q ? VS_POL : ~VS_POL;
            hdmi_de     <= act1_q;
            frame_start <= sof1_q && act1_q;
            {hdmi_r, hdmi_g, hdmi_b} <= rgb_d;
        end
    end
endmodule

// File: tb/tb_hdmi_timing_pattern_gen.sv
module tb_hdmi_timing_pattern_gen;
    localparam int HA = 324, HFP = 8, HSY = 16, HBP = 16;
    localparam int VA = 36,  VFP = 2, VSY = 2,  VBP = 2;
    localparam logic HS_POL = 1'b0, VS_POL = 1'b0;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam int BARW = HA / 8;
    localparam logic [31:0] RST_OUT = {4'b0, ~HS_POL, ~VS_POL, 1'b0, 1'b0, 24'h000000};

    localparam int NSP = 19;
    int          sp_f[NSP] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 3, 3};
    int          sp_x[NSP] = '{0, 39, 40, 80, 120, 160, 200, 240, 280, 323, 330,
                               0, 32, 32, 0, 300, 10, 5, 323};
    int          sp_y[NSP] = '{0, 0, 0, 0, 5, 5, 5, 5, 0, 0, 0, 0, 0, 32, 32, 3, 3, 5, 35};
    logic [23:0] sp_c[NSP] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000,
                               24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000,
                               24'h2C2C2C, 24'h0A0A0A, 24'h123456, 24'h123456};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic        hdmi_hs, hdmi_vs, hdmi_de, frame_start;
    logic [7:0]  hdmi_r, hdmi_g, hdmi_b;
    logic [31:0] obs;

    int n_tests = 0, n_fail = 0;
    int e = 0;
    logic [1:0]  lat_pat[8];
    logic [23:0] lat_rgb[8];
    int first_de, de_rise, hs_fall, vs_fall, last_fs;
    logic prev_de, prev_hs, prev_vs, spots_on;

    hdmi_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .clk(clk), .rst(rst), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs), .hdmi_de(hdmi_de),
        .hdmi_r(hdmi_r), .hdmi_g(hdmi_g), .hdmi_b(hdmi_b), .frame_start(frame_start)
    );

    always #5 clk = ~clk;
    assign obs = {4'b0, hdmi_hs, hdmi_vs, hdmi_de, frame_start, hdmi_r, hdmi_g, hdmi_b};

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] x);
        n_tests++;
        assert (o === x) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, e, o, x);
        end
    endtask

    function automatic logic [23:0] bar_colour(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected output for raster pixel number p counted from the first (0,0)
    function automatic logic [31:0] model(input int p, input logic [1:0] pat, input logic [23:0] col);
        int x, y;
        logic act, h, v, s;
        logic [23:0] c;
        logic [7:0] g8;
        x   = p % HT;
        y   = (p / HT) % VT;
        act = (x < HA) && (y < VA);
        h   = (x >= HA + HFP && x < HA + HFP + HSY) ? HS_POL : ~HS_POL;
        v   = (y >= VA + VFP && y < VA + VFP + VSY) ? VS_POL : ~VS_POL;
        s   = (x == 0) && (y == 0);
        g8  = 8'(x % 256);
        c   = 24'h0;
        if (act) begin
            case (pat)
                2'd0: c = (x / BARW < 8) ? bar_colour(x / BARW) : 24'h0;
                2'd1: c = {g8, g8, g8};
                2'd2: c = (((x / 32) + (y / 32)) % 2 == 0) ? 24'hFFFFFF : 24'h0;
                default: c = col;
            endcase
        end
        return {4'b0, h, v, act, s, c};
    endfunction

    task automatic reset_trackers();
        e = 0; first_de = -1; de_rise = -1; hs_fall = -1; vs_fall = -1; last_fs = -1;
        prev_de = 1'b0; prev_hs = ~HS_POL; prev_vs = ~VS_POL;
    endtask

    task automatic step();
        int p, f, x, y;
        logic [31:0] ex;
        @(posedge clk);
        e++;
        if ((e - 1) % FT == 0) begin
            lat_pat[(e - 1) / FT] = pattern_sel;
            lat_rgb[(e - 1) / FT] = solid_rgb;
        end
        @(negedge clk);
        p = e - 2;
        if (e < 2) ex = RST_OUT;
        else       ex = model(p, lat_pat[p / FT], lat_rgb[p / FT]);
        check("pixel", obs, ex);
        if (spots_on && e >= 2) begin
            f = p / FT; x = p % HT; y = (p / HT) % VT;
            for (int i = 0; i < NSP; i++)
                if (sp_f[i] == f && sp_x[i] == x && sp_y[i] == y)
                    check($sformatf("spot%0d", i), {8'h0, hdmi_r, hdmi_g, hdmi_b}, {8'h0, sp_c[i]});
        end
        if (hdmi_de && !prev_de) begin
            de_rise = e;
            if (first_de < 0) first_de = e;
        end
        if (!hdmi_de && prev_de) check("de_width", e - de_rise, HA);
        if (hdmi_hs != HS_POL && prev_hs == HS_POL && hs_fall >= 0) check("hs_width", e - hs_fall, HSY);
        if (hdmi_hs == HS_POL && prev_hs != HS_POL) begin
            hs_fall = e;
            if (de_rise >= 0 && e - de_rise < HT) check("hs_offset", e - de_rise, HA + HFP);
        end
        if (hdmi_vs != VS_POL && prev_vs == VS_POL && vs_fall >= 0) check("vs_width", e - vs_fall, VSY * HT);
        if (hdmi_vs == VS_POL && prev_vs != VS_POL) begin
            vs_fall = e;
            if (last_fs >= 0) check("vs_offset", e - last_fs, (VA + VFP) * HT);
        end
        if (frame_start) begin
            if (last_fs >= 0) check("fs_period", e - last_fs, FT);
            last_fs = e;
        end
        prev_de = hdmi_de; prev_hs = hdmi_hs; prev_vs = hdmi_vs;
    endtask

    task automatic run_until(input int target);
        while (e < target) step();
    endtask

    initial begin
        if (!(HA >= 8 && HFP >= 1 && HSY >= 1 && HBP >= 1 && VA >= 1 && VFP >= 1 && VSY >= 1 && VBP >= 1))
            $fatal(1, "bench parameters outside the allowed range");
        reset_trackers();
        spots_on = 1'b1;
        solid_rgb = 24'($urandom);
        repeat (10) begin
            @(negedge clk);
            check("reset_hold", obs, RST_OUT);
        end
        rst = 1'b0;

        // Per frame: random ignored change mid-frame, then the pattern for the next frame
        for (int k = 0; k < 4; k++) begin
            run_until(k * FT + int'($urandom_range(2, 9 * HT)));
            pattern_sel = 2'($urandom_range(0, 3));
            solid_rgb   = 24'($urandom);
            run_until(k * FT + 10 * HT);
            case (k)
                0: pattern_sel = 2'd2;
                1: pattern_sel = 2'd1;
                2: pattern_sel = 2'd3;
                default: pattern_sel = 2'd0;
            endcase
            solid_rgb = (k == 2) ? 24'h123456 : 24'($urandom);
            if (k == 0) check("first_de", first_de, 2);
        end

        // Asynchronous reset at pixel 300 of line 7
        run_until(4 * FT + 7 * HT + 300);
        rst = 1'b1;
        #1 check("async_reset", obs, RST_OUT);
        pattern_sel = 2'd1;
        repeat (3) begin
            @(negedge clk);
            check("reset_hold2", obs, RST_OUT);
        end
        rst = 1'b0;
        reset_trackers();
        spots_on = 1'b0;
        run_until(2 * HT + 10);
        check("first_de_restart", first_de, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
